// File: rtl/gemv_pkg.sv
// -----------------------------------------------------------------------------
// gemv_pkg
// Shared GEMV definitions used by the systolic array, its cells and the
// sequencer that feeds it. Element/result width and array length are defined
// here once, so every block that touches the array agrees on them.
// No ports (package).
// -----------------------------------------------------------------------------
package gemv_pkg;

    // Element and result width in bits (results wrap modulo 2^GEMV_DW).
    localparam int GEMV_DW    = 16;

    // Number of lanes (elements per row) in the systolic array.
    localparam int GEMV_SZ    = 4;

    // Default result FIFO depth; must be at least GEMV_SZ + 1.
    localparam int GEMV_DEPTH = 8;

endpackage : gemv_pkg

// File: rtl/gemv_out_fifo.sv
// -----------------------------------------------------------------------------
// gemv_out_fifo
// Result FIFO for the GEMV sequencer. Pointers wrap modulo DEPTH and a
// separate occupancy count tells full from empty. The head entry is presented
// on pop_data straight from storage, so it holds steady until it is popped.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset (clears pointers, count, storage)
//   push       : write push_data this cycle
//   push_data  : [DW-1:0] value to store
//   pop        : consume the head entry this cycle (ignored when empty)
//   pop_data   : [DW-1:0] head entry
//   count      : number of entries held
// -----------------------------------------------------------------------------
module gemv_out_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [DW-1:0]              pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             pop_ok;
    logic             push_ok;

    // Advance a pointer, wrapping from DEPTH-1 back to 0 (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1'b1);
        end
        return nxt;
    endfunction

    // Qualify push/pop and compute next pointers and occupancy.
    always_comb begin
        pop_ok   = pop && (count_q != {CNT_W{1'b0}});
        // A push into a full FIFO is still safe when the head leaves in the same cycle.
        push_ok  = push && ((count_q != CNT_FULL) || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Result storage; cleared on reset so the head output is never undefined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= {DW{1'b0}};
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule : gemv_out_fifo

// File: rtl/gemv_sequencer.sv
// -----------------------------------------------------------------------------
// gemv_sequencer
// Feeds one matrix row and the vector into an external SZ-lane systolic array
// per accepted transfer, skewing lane i by i+1 cycles, and collects the
// array's dot-product output into a result FIFO in acceptance order.
// Acceptance is credit based: a row is only taken when the rows in flight
// plus the results already queued leave a free FIFO entry, so no result can
// ever be dropped.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : a row is offered
//   in_ready  : row accepted when in_valid && in_ready
//   in_w      : [SZ-1:0][DW-1:0] matrix row, element i on index i
//   in_a      : [SZ-1:0][DW-1:0] vector, element i on index i
//   arr_w     : [SZ-1:0][DW-1:0] skewed weights to the array W input
//   arr_a     : [SZ-1:0][DW-1:0] skewed activations to the array A input
//   arr_o     : [DW-1:0] array output O
//   out_valid : a result is available
//   out_ready : result consumed when out_valid && out_ready
//   out_data  : [DW-1:0] dot-product result (mod 2^DW)
// -----------------------------------------------------------------------------
module gemv_sequencer
    import gemv_pkg::*;
#(
    parameter int DW    = GEMV_DW,
    parameter int SZ    = GEMV_SZ,
    parameter int DEPTH = GEMV_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SZ-1:0][DW-1:0]  in_w,
    input  logic [SZ-1:0][DW-1:0]  in_a,
    output logic [SZ-1:0][DW-1:0]  arr_w,
    output logic [SZ-1:0][DW-1:0]  arr_a,
    input  logic [DW-1:0]          arr_o,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

    logic             accept;
    logic             retire;
    logic             pop;
    logic [SZ:0]      vld_q;
    logic [SZ:0]      vld_d;
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] inflight_d;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_used;

    // Credits come only from registered counts; rst forces the port low while asserted.
    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign in_ready    = !rst && (credit_used < CREDIT_LIMIT);
    assign accept      = in_valid && in_ready;
    // The last valid stage marks the cycle in which arr_o carries that row's result.
    assign retire      = vld_q[SZ];
    assign out_valid   = (fifo_count != {CNT_W{1'b0}});
    assign pop         = out_valid && out_ready;

    // Skew chains: lane i is delayed i+1 cycles and carries zero when no row occupies it.
    for (genvar i = 0; i < SZ; i++) begin : g_lane
        logic [DW-1:0] w_q [i+1];
        logic [DW-1:0] w_d [i+1];
        logic [DW-1:0] a_q [i+1];
        logic [DW-1:0] a_d [i+1];

        // Load the lane element on acceptance (zero otherwise) and shift the chain.
        always_comb begin
            if (accept) begin
                w_d[0] = in_w[i];
                a_d[0] = in_a[i];
            end else begin
                w_d[0] = {DW{1'b0}};
                a_d[0] = {DW{1'b0}};
            end
            for (int j = 1; j <= i; j++) begin
                w_d[j] = w_q[j-1];
                a_d[j] = a_q[j-1];
            end
        end

        // Skew chain registers for this lane.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= i; j++) begin
                    w_q[j] <= {DW{1'b0}};
                    a_q[j] <= {DW{1'b0}};
                end
            end else begin
                for (int j = 0; j <= i; j++) begin
                    w_q[j] <= w_d[j];
                    a_q[j] <= a_d[j];
                end
            end
        end

        assign arr_w[i] = w_q[i];
        assign arr_a[i] = a_q[i];
    end

    // Valid shift register and in-flight credit count.
    always_comb begin
        vld_d = {vld_q[SZ-1:0], accept};
        case ({accept, retire})
            2'b10:   inflight_d = inflight_q + CNT_W'(1'b1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1'b1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Valid pipeline and in-flight count; reset drops every row still in the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q      <= {(SZ + 1){1'b0}};
            inflight_q <= {CNT_W{1'b0}};
        end else begin
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
        end
    end

    gemv_out_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (retire),
        .push_data (arr_o),
        .pop       (pop),
        .pop_data  (out_data),
        .count     (fifo_count)
    );

endmodule : gemv_sequencer

// File: tb/tb_gemv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gemv_sequencer
// Directed bench for gemv_sequencer (DW=16, SZ=4, DEPTH=8) with a behavioural
// systolic array attached: cell i adds arr_w[i]*arr_a[i] to the partial sum of
// cell i-1 and registers it, so arr_o is the full dot product one cycle after
// lane SZ-1 is driven. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_gemv_sequencer;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0][15:0]  in_w;
    logic [3:0][15:0]  in_a;
    logic [3:0][15:0]  arr_w;
    logic [3:0][15:0]  arr_a;
    logic [15:0]       arr_o;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_data;

    int checks;
    int failures;
    int acc;
    int n;
    int lat;
    logic found;

    logic [15:0] psum [4];

    gemv_sequencer #(
        .DW    (16),
        .SZ    (4),
        .DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_w      (in_w),
        .in_a      (in_a),
        .arr_w     (arr_w),
        .arr_a     (arr_a),
        .arr_o     (arr_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mul16(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        p = {16'd0, x} * {16'd0, y};
        return p[15:0];
    endfunction

    // Behavioural array: not reset, so stale partial sums keep flowing after a reset.
    always @(posedge clk) begin
        psum[0] <= mul16(arr_w[0], arr_a[0]);
        for (int i = 1; i < 4; i++) begin
            psum[i] <= psum[i-1] + mul16(arr_w[i], arr_a[i]);
        end
    end
    assign arr_o = psum[3];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_row(input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3,
                           input logic [15:0] a0, input logic [15:0] a1,
                           input logic [15:0] a2, input logic [15:0] a3);
        in_w[0] = w0; in_w[1] = w1; in_w[2] = w2; in_w[3] = w3;
        in_a[0] = a0; in_a[1] = a1; in_a[2] = a2; in_a[3] = a3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_row(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        for (int i = 0; i < 4; i++) psum[i] = 16'd0;

        // Reset state
        repeat (3) step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_arr_w", 64'(arr_w), 64'd0);
        check("rst_arr_a", 64'(arr_a), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single row, accepted in cycle 0: 1*5+2*6+3*7+4*8 = 70
        set_row(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
        in_valid = 1'b1;
        step();                                   // cycle 1
        in_valid = 1'b0;
        check("single_c1_lane0_w", 64'(arr_w[0]), 64'd1);
        check("single_c1_lane0_a", 64'(arr_a[0]), 64'd5);
        check("single_c1_lane3_w", 64'(arr_w[3]), 64'd0);
        step(); step(); step();                   // cycle 4
        check("single_c4_lane3_w", 64'(arr_w[3]), 64'd4);
        check("single_c4_lane3_a", 64'(arr_a[3]), 64'd8);
        check("single_c4_lane0_w", 64'(arr_w[0]), 64'd0);
        step();                                   // cycle 5
        check("single_c5_out_valid", 64'(out_valid), 64'd0);
        step();                                   // cycle 6
        check("single_c6_out_valid", 64'(out_valid), 64'd1);
        check("single_c6_out_data", 64'(out_data), 64'd70);
        step();                                   // cycle 7
        check("single_c7_out_valid", 64'(out_valid), 64'd0);

        // Streaming: four back-to-back rows, results 10, 14, 300, 307 in cycles 6..9
        set_row(16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd3, 16'd4);
        in_valid = 1'b1;
        check("stream_c0_in_ready", 64'(in_ready), 64'd1);
        step();
        set_row(16'd2, 16'd3, 16'd4, 16'd5, 16'd1, 16'd1, 16'd1, 16'd1);
        check("stream_c1_in_ready", 64'(in_ready), 64'd1);
        step();
        set_row(16'd10, 16'd20, 16'd30, 16'd40, 16'd1, 16'd2, 16'd3, 16'd4);
        check("stream_c2_in_ready", 64'(in_ready), 64'd1);
        step();
        set_row(16'd100, 16'd0, 16'd0, 16'd1, 16'd3, 16'd0, 16'd0, 16'd7);
        check("stream_c3_in_ready", 64'(in_ready), 64'd1);
        step();                                   // cycle 4
        in_valid = 1'b0;
        step();                                   // cycle 5
        check("stream_c5_out_valid", 64'(out_valid), 64'd0);
        step();                                   // cycle 6
        check("stream_c6_out_valid", 64'(out_valid), 64'd1);
        check("stream_c6_out_data", 64'(out_data), 64'd10);
        step();
        check("stream_c7_out_valid", 64'(out_valid), 64'd1);
        check("stream_c7_out_data", 64'(out_data), 64'd14);
        step();
        check("stream_c8_out_valid", 64'(out_valid), 64'd1);
        check("stream_c8_out_data", 64'(out_data), 64'd300);
        step();
        check("stream_c9_out_valid", 64'(out_valid), 64'd1);
        check("stream_c9_out_data", 64'(out_data), 64'd307);
        step();
        check("stream_c10_out_valid", 64'(out_valid), 64'd0);

        // Backpressure: row k is w0=k+1, a0=3 -> result 3*(k+1)
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc       = 0;
        for (int c = 0; c < 16; c++) begin
            set_row(16'(acc + 1), 16'd0, 16'd0, 16'd0, 16'd3, 16'd0, 16'd0, 16'd0);
            if (in_ready) acc++;
            step();
        end
        check("bp_accepted", 64'(acc), 64'd8);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_head_data", 64'(out_data), 64'd3);
        step(); step();
        check("bp_head_stable", 64'(out_data), 64'd3);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n         = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                check("bp_drain_data", 64'(out_data), 64'(3 * (n + 1)));
                n++;
            end
            step();
        end
        check("bp_drain_count", 64'(n), 64'd8);
        check("bp_drained_out_valid", 64'(out_valid), 64'd0);
        check("bp_drained_in_ready", 64'(in_ready), 64'd1);

        // Mid-operation reset with two rows in flight
        set_row(16'd9, 16'd9, 16'd9, 16'd9, 16'd1, 16'd1, 16'd1, 16'd1);
        in_valid = 1'b1;
        step();
        set_row(16'd7, 16'd7, 16'd7, 16'd7, 16'd2, 16'd2, 16'd2, 16'd2);
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_in_ready", 64'(in_ready), 64'd0);
        check("mrst_arr_w", 64'(arr_w), 64'd0);
        check("mrst_arr_a", 64'(arr_a), 64'd0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check("mrst_no_result", 64'(out_valid), 64'd0);
        end

        // Wrap-around: 0x8000*2 + 0xFFFF*1 = 0x1FFFF -> 0xFFFF, expected in cycle 6
        set_row(16'h8000, 16'hFFFF, 16'd0, 16'd0, 16'd2, 16'd1, 16'd0, 16'd0);
        in_valid = 1'b1;
        check("wrap_in_ready", 64'(in_ready), 64'd1);
        found = 1'b0;
        lat   = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            in_valid = 1'b0;
            if (!found && out_valid) begin
                found = 1'b1;
                lat   = c;
                check("wrap_out_data", 64'(out_data), 64'hFFFF);
            end
        end
        check("wrap_seen", 64'(found), 64'd1);
        check("wrap_latency", 64'(lat), 64'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_gemv_sequencer

// File: doc/gemv_sequencer.md
GEMV_SEQUENCER -- requirements
Module: gemv_sequencer

Interface
REQ-001 SHALL have parameter DW, default 16: element and result width in bits.
REQ-002 SHALL have parameter SZ, default 4: array length (lanes per row), SZ >= 2.
REQ-003 SHALL have parameter DEPTH, default 8: result FIFO entries, DEPTH >= SZ+1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: a row is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the row is accepted when in_valid && in_ready.
REQ-008 SHALL have port in_w, input, [DW-1:0] x SZ: matrix row.
REQ-009 SHALL have port in_a, input, [DW-1:0] x SZ: vector.
REQ-010 SHALL have port arr_w, output, [DW-1:0] x SZ: skewed weights to the systolic array W input.
REQ-011 SHALL have port arr_a, output, [DW-1:0] x SZ: skewed activations to the array A input.
REQ-012 SHALL have port arr_o, input, [DW-1:0]: array output O.
REQ-013 SHALL have port out_valid, output, 1 bit: a result is available.
REQ-014 SHALL have port out_ready, input, 1 bit: the result is consumed when out_valid && out_ready.
REQ-015 SHALL have port out_data, output, [DW-1:0]: dot-product result.

Function
REQ-016 SHALL, for a row accepted in cycle t, drive lane i of arr_w/arr_a with element i during cycle t+1+i only (skew register chain of depth i+1).
REQ-017 SHALL drive 0 on every lane in cycles where no accepted row occupies that lane.
REQ-018 SHALL track in-flight rows with an SZ+1 stage valid shift register; stage SZ+1 set means arr_o is valid in cycle t+SZ+1.
REQ-019 SHALL write arr_o into the result FIFO at the end of cycle t+SZ+1, so that out_valid rises in cycle t+SZ+2 when the FIFO was empty.
REQ-020 SHALL present results in acceptance order; out_data is stable while out_valid && !out_ready.
REQ-021 SHALL define the result as sum over i of in_w[i]*in_a[i], modulo 2^DW (matching array truncation).
REQ-022 SHALL drive in_ready = (inflight_count + fifo_count) < DEPTH from registered counts only (no combinational path from out_ready or in_valid).
REQ-023 SHALL apply the credit update inflight_count' = inflight_count + accept - retire on every cycle in which acceptance, retirement into the FIFO and a FIFO pop coincide; no result is ever dropped.
REQ-024 SHALL accept one row per cycle back-to-back while credits allow.
REQ-025 SHALL implement the FIFO pointers as wrap-around mod DEPTH, with a separate count distinguishing full from empty.

Reset
REQ-026 SHALL, on rst, asynchronously clear the skew registers, the valid shift register, the FIFO pointers/count and inflight_count.
REQ-027 SHALL drive out_valid=0, in_ready=0 and arr_w/arr_a=0 while rst=1; in_ready=1 in the first cycle after release.
REQ-028 SHALL discard rows in flight at a mid-operation reset; stale arr_o values (the array itself is not reset) never reach the FIFO.

Structure
REQ-029 SHALL take DW and SZ from the shared GEMV definitions package/header used by the array and cell.
REQ-030 SHALL place the result FIFO in one sub-module, gemv_out_fifo (DW, DEPTH, push/pop/count).
REQ-031 SHALL NOT instantiate the array; the top level connects arr_* to it.

Verification (SZ=4, DW=16, DEPTH=8, array model attached)
REQ-032 SHALL cover a single row: in_w=[1,2,3,4], in_a=[5,6,7,8] accepted in cycle 0 -> arr lane 3 = (4,8) in cycle 4; out_valid in cycle 6 with out_data=70.
REQ-033 SHALL cover streaming: 4 back-to-back rows with out_ready=1 -> in_ready stays 1; 4 results on consecutive cycles 6..9, in order.
REQ-034 SHALL cover backpressure: out_ready=0 with in_valid held -> exactly 8 rows accepted, then in_ready=0; releasing out_ready drains 8 results in order with none lost.
REQ-035 SHALL cover wrap-around: in_w=[0x8000,0xFFFF,0,0], in_a=[2,1,0,0] -> out_data=0xFFFF.
REQ-036 SHALL cover mid-operation reset: rst pulsed with 2 rows in flight -> out_valid=0, and no result appears for 10 cycles after release without new input.
